// File: rtl/buffer_stream_pkg.sv
// Shared types for the scratch-buffer word streamer.
// Holds the sequencer state encoding and the FIFO entry layout.
package buffer_stream_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/buffer_word_streamer_if.sv
// Valid/ready word stream from the streamer to the compute array.
// master drives data, slave returns ready.
interface buffer_word_streamer_if;
    import buffer_stream_pkg::*;

    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module stream_fifo
    import buffer_stream_pkg::*;
#(
    parameter int Depth = 4,
    parameter int CntW  = $clog2(Depth) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  fifo_entry_t     wdata_i,
    input  logic            pop_i,
    output fifo_entry_t     rdata_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int PtrW = $clog2(Depth);

    fifo_entry_t     mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage needs no reset; the count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/buffer_word_streamer.sv
// Read-side sequencer: fetches a run of buffer words and streams them out.
// Reads are issued only against free FIFO credit, so no word is ever lost.
module buffer_word_streamer
    import buffer_stream_pkg::*;
#(
    parameter int WordDepth = 32,
    parameter int WordAddrW = $clog2(WordDepth),
    parameter int LenW      = WordAddrW + 1,
    parameter int FifoDepth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WordAddrW-1:0]  base_addr,
    input  logic [LenW-1:0]       length,
    output logic                  busy,
    output logic                  done,
    output logic                  buf_read_en,
    output logic                  buf_addr_mode,
    output logic [WordAddrW-1:0]  buf_word_addr,
    input  logic [WORD_W-1:0]     buf_word_in,
    buffer_word_streamer_if.master m
);

    localparam int CntW = $clog2(FifoDepth) + 1;
    localparam logic [WordAddrW-1:0] AddrMax = WordAddrW'(WordDepth - 1);
    localparam logic [CntW:0]        Credits = (CntW + 1)'(FifoDepth);

    state_e               state_q;
    logic [WordAddrW-1:0] addr_q;
    logic [WordAddrW-1:0] addr_d;
    logic [LenW-1:0]      remain_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 infl_q;
    logic                 infl_last_q;

    logic [CntW-1:0]      fifo_cnt;
    logic                 fifo_empty;
    fifo_entry_t          wr_entry;
    fifo_entry_t          head;
    logic [CntW:0]        used;
    logic                 issue;
    logic                 last_issue;
    logic                 pop;
    logic                 final_pop;

    // The word still in the buffer pipe already owns a FIFO slot.
    assign used       = {1'b0, fifo_cnt} + {{CntW{1'b0}}, infl_q};
    assign issue      = (state_q == FETCH) && (used < Credits);
    assign last_issue = issue && (remain_q == LenW'(1));
    assign addr_d     = (addr_q == AddrMax) ? '0 : addr_q + WordAddrW'(1);

    assign pop       = m.m_valid && m.m_ready;
    assign final_pop = pop && head.last;
    assign wr_entry  = {infl_last_q, buf_word_in};

    stream_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (infl_q),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign m.m_valid = !fifo_empty;
    assign m.m_data  = fifo_empty ? '0 : head.data;
    assign m.m_last  = !fifo_empty && head.last;

    assign buf_read_en   = issue;
    assign buf_addr_mode = 1'b0;
    assign buf_word_addr = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q      <= issue;
            infl_last_q <= last_issue;
            done_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q   <= base_addr;
                        remain_q <= length;
                        busy_q   <= 1'b1;
                        if (length == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        addr_q   <= addr_d;
                        remain_q <= remain_q - LenW'(1);
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (final_pop) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_word_streamer.sv
// Bench for buffer_word_streamer: vector table, corner sequences, random runs.
// Expected streams come from a flat model of the buffer contents.
module tb_buffer_word_streamer;

    localparam int WD = 32;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  base_addr;
    logic [5:0]  length;
    logic        busy;
    logic        done;
    logic        buf_read_en;
    logic        buf_addr_mode;
    logic [4:0]  buf_word_addr;
    logic [63:0] buf_word_in;

    buffer_word_streamer_if s_if ();

    buffer_word_streamer #(
        .WordDepth (WD),
        .FifoDepth (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .buf_read_en   (buf_read_en),
        .buf_addr_mode (buf_addr_mode),
        .buf_word_addr (buf_word_addr),
        .buf_word_in   (buf_word_in),
        .m             (s_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: registered word read, one cycle latency
    logic [63:0] mem [WD];
    always @(posedge clk) begin
        if (buf_read_en) buf_word_in <= mem[buf_word_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Ready driver
    int ready_mode = 0;
    int stall_left = 0;
    initial begin
        s_if.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: s_if.m_ready = 1'b1;
                1: s_if.m_ready = 1'($urandom % 2);
                2: begin
                    if (stall_left > 0) begin
                        s_if.m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        s_if.m_ready = 1'b1;
                    end
                end
                default: s_if.m_ready = 1'b0;
            endcase
        end
    end

    // Monitor, sampled mid-cycle
    bit          mon_en = 0;
    int          busy_cnt, done_cnt, done_cyc, rd_pre, inv_err;
    bit          hs_seen, prev_stall;
    logic [64:0] prev_word;
    logic [64:0] got_q [$];
    int          cyc_q [$];
    int          rd_q [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (buf_addr_mode) inv_err++;
            if (buf_read_en) begin
                rd_q.push_back(int'(buf_word_addr));
                if (!hs_seen) rd_pre++;
                if (!busy) inv_err++;
            end
            if (prev_stall && (!s_if.m_valid ||
                {s_if.m_last, s_if.m_data} != prev_word)) inv_err++;
            if (s_if.m_valid && s_if.m_ready) begin
                got_q.push_back({s_if.m_last, s_if.m_data});
                cyc_q.push_back(cyc);
                hs_seen = 1;
            end
            if (rd_q.size() - got_q.size() > FD) inv_err++;
            prev_stall = s_if.m_valid && !s_if.m_ready;
            prev_word  = {s_if.m_last, s_if.m_data};
        end
    end

    task automatic mon_clear();
        got_q.delete();
        cyc_q.delete();
        rd_q.delete();
        busy_cnt   = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        rd_pre     = 0;
        inv_err    = 0;
        hs_seen    = 0;
        prev_stall = 0;
    endtask

    task automatic do_xfer(input string tag, input int b, input int l,
                           input int mode, input int exp_busy,
                           input int exp_stall, input int restart);
        int          e0;
        int          a;
        bit          fin;
        logic [64:0] exp_w;
        ready_mode = mode;
        stall_left = 10;
        mon_clear();
        mon_en = 1;
        @(posedge clk);
        #1;
        base_addr = 5'(b);
        length    = 6'(l);
        start     = 1'b1;
        @(posedge clk);
        #1;
        e0        = cyc;
        start     = 1'b0;
        base_addr = 5'($urandom);
        length    = 6'($urandom);
        fin = 0;
        for (int k = 0; k < 400 && !fin; k++) begin
            if (restart >= 0 && cyc - e0 == restart) begin
                base_addr = 5'd20;
                length    = 6'd2;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_cnt > 0) fin = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: done not seen in 400 cycles", tag);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        mon_en = 0;
        chk({tag, ".words"}, 65'(got_q.size()), 65'(l));
        chk({tag, ".reads"}, 65'(rd_q.size()), 65'(l));
        for (int k = 0; k < l; k++) begin
            a     = (b + k) % WD;
            exp_w = {k == l - 1, mem[a]};
            if (k < got_q.size())
                chk($sformatf("%s.word%0d", tag, k), got_q[k], exp_w);
            if (k < rd_q.size())
                chk($sformatf("%s.addr%0d", tag, k), 65'(rd_q[k]), 65'(a));
        end
        chk({tag, ".done_cnt"}, 65'(done_cnt), 65'(1));
        chk({tag, ".busy_end"}, 65'(busy), 65'(0));
        chk({tag, ".inv"}, 65'(inv_err), 65'(0));
        if (exp_busy >= 0)
            chk({tag, ".busy_cyc"}, 65'(busy_cnt), 65'(exp_busy));
        if (exp_stall >= 0)
            chk({tag, ".stall_rd"}, 65'(rd_pre), 65'(exp_stall));
        if (l == 0)
            chk({tag, ".done_t"}, 65'(done_cyc), 65'(e0));
        else if (got_q.size() == l)
            chk({tag, ".done_t"}, 65'(done_cyc), 65'(cyc_q[l-1] + 1));
        if (mode == 0 && l > 0 && got_q.size() == l) begin
            chk({tag, ".first_t"}, 65'(cyc_q[0]), 65'(e0 + 2));
            chk({tag, ".last_t"}, 65'(cyc_q[l-1]), 65'(e0 + l + 1));
        end
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        int exp_busy;
        int exp_stall;
        int restart;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int e0;
        int b, l, mode;
        vecs[0] = '{4, 3, 0, 6, -1, -1};
        vecs[1] = '{30, 4, 0, 7, -1, -1};
        vecs[2] = '{0, 0, 0, 1, -1, -1};
        vecs[3] = '{31, 1, 0, 4, -1, -1};
        vecs[4] = '{5, 32, 0, 35, -1, -1};
        vecs[5] = '{12, 3, 2, -1, 3, -1};
        vecs[6] = '{12, 8, 2, -1, 4, -1};
        vecs[7] = '{9, 6, 1, -1, -1, -1};
        vecs[8] = '{8, 6, 0, 9, -1, 3};

        for (int i = 0; i < WD; i++)
            mem[i] = 64'hD00D_0000_0000_0000 | 64'(i);

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 65'(busy), 65'(0));
        chk("reset.done", 65'(done), 65'(0));
        chk("reset.rd_en", 65'(buf_read_en), 65'(0));
        chk("reset.addr", 65'(buf_word_addr), 65'(0));
        chk("reset.valid", 65'(s_if.m_valid), 65'(0));
        chk("reset.data", 65'(s_if.m_data), 65'(0));
        chk("reset.last", 65'(s_if.m_last), 65'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            do_xfer($sformatf("vec%0d", i), vecs[i].base, vecs[i].len,
                    vecs[i].mode, vecs[i].exp_busy, vecs[i].exp_stall,
                    vecs[i].restart);

        // Reset with two words sitting in the FIFO
        ready_mode = 3;
        mon_clear();
        @(posedge clk);
        #1;
        base_addr = 5'd0;
        length    = 6'd8;
        start     = 1'b1;
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mrst.pre_valid", 65'(s_if.m_valid), 65'(1));
        chk("mrst.pre_cnt", 65'(cyc - e0), 65'(3));
        rst = 1'b1;
        #1;
        chk("mrst.valid", 65'(s_if.m_valid), 65'(0));
        chk("mrst.data", 65'(s_if.m_data), 65'(0));
        chk("mrst.last", 65'(s_if.m_last), 65'(0));
        chk("mrst.busy", 65'(busy), 65'(0));
        chk("mrst.done", 65'(done), 65'(0));
        chk("mrst.rd_en", 65'(buf_read_en), 65'(0));
        chk("mrst.addr", 65'(buf_word_addr), 65'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_xfer("mrst.w7", 7, 1, 0, 4, -1, -1);

        for (int i = 0; i < 15; i++) begin
            for (int j = 0; j < WD; j++)
                mem[j] = {$urandom, $urandom};
            b    = $urandom_range(0, WD - 1);
            l    = $urandom_range(0, WD);
            mode = $urandom_range(0, 1);
            do_xfer($sformatf("rnd%0d", i), b, l, mode,
                    (mode == 0) ? ((l == 0) ? 1 : l + 3) : -1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buffer_word_streamer.md
# buffer_word_streamer

Read-side sequencer for the 64-bit scratch buffer. On a start command it fetches a contiguous run of 64-bit words from the buffer's word-mode read port and presents them as a valid/ready stream to the downstream compute array. A small first-word-fall-through (FWFT) FIFO absorbs backpressure. Credit-based read issue means no word is ever dropped.

## Interface
- WordDepth, 32, number of 64-bit words in the buffer
- WordAddrW, $clog2(WordDepth), word address width
- LenW, WordAddrW+1, width of transfer length (max WordDepth words)
- FifoDepth, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock (one clock domain; reset is asynchronous and active-high)
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin transfer; sampled only in IDLE
- base_addr  in  WordAddrW  first word address
- length  in  LenW  words to transfer; 0 = no-op
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at transfer end
- buf_read_en  out  1  buffer read strobe
- buf_addr_mode  out  1  held 0 (selects word addressing on buffer port)
- buf_word_addr  out  WordAddrW  buffer word address
- buf_word_in  in  64  buffer read data, valid one cycle after buf_read_en
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accept
- m_data  out  64  stream word
- m_last  out  1  marks final word of transfer (qualified by m_valid)

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 latches base_addr/length, sets busy. length≠0 → FETCH; length=0 → DONE, with no reads issued.
- FETCH: issues buf_read_en when (fifo_count + inflight) < FifoDepth.
  - Each issue increments the address modulo WordDepth (wraps WordDepth-1 → 0) and decrements the remaining-issue counter.
  - Last issue → DRAIN.
- inflight: one-bit pipe flag set in the cycle buf_read_en is high. When the flag is set, buf_word_in is pushed into the FIFO on the next edge. buf_word_in is never sampled otherwise.
- DRAIN: no reads. Stay until the FIFO is empty, inflight=0, and the final word has handshaken → DONE.
- DONE: done=1 for one cycle, busy drops → IDLE.
- Handshake: transfer occurs when m_valid && m_ready. m_data/m_last stay stable while m_valid && !m_ready.
- m_last is carried as a 65th FIFO bit, set on the word whose issue count equals length.
- start while busy is ignored. base_addr/length changes after acceptance are ignored.
- buf_read_en is never high in IDLE, DRAIN, or DONE.
- Reset (any time, including mid-transfer): FSM → IDLE, FIFO flushed, counters cleared, inflight cleared. All outputs 0; buf_word_addr = 0.

## Timing
- start sampled at edge E0. buf_read_en is high in the cycle after E0. buffer data is registered at E1; FIFO write at E2; m_valid=1 after E2.
- First-word latency is 2 cycles from the start edge.
- Throughput is 1 word/cycle when m_ready is held high.
- Total for N words with m_ready=1:
  - last handshake at E(N+1);
  - done high in the cycle after E(N+1);
  - busy low after E(N+2).
- FIFO full: read issue stalls the same cycle, because the credit check counts the inflight word. FIFO never overflows.
- Simultaneous FIFO push and pop: count unchanged, both succeed.
- FIFO empty with a push in progress: m_valid rises the cycle after the push edge. No combinational bypass from buf_word_in to m_data.

## Structure
- Package buffer_stream_pkg holds:
  - state enum (IDLE, FETCH, DRAIN, DONE);
  - WORD_W=64 constant;
  - FIFO entry type {last, data[63:0]}.
- Sub-module stream_fifo: parameterised synchronous FWFT FIFO with count output, asynchronous active-high reset.
- The top level contains the FSM, address/length counters, inflight flag, and credit logic.

## Test plan
- base_addr=4, length=3, m_ready=1, buffer words = 0x..04/05/06 → m_data 0x..04,0x..05,0x..06 on consecutive cycles starting 2 cycles after start; m_last on third word; done one cycle after.
- base_addr=30, length=4, WordDepth=32 → reads addresses 30,31,0,1 in order; stream data matches.
- length=3, m_ready=0 for 10 cycles then 1 → at most FifoDepth reads issued while stalled; no loss or reorder; m_data stable while stalled.
- length=0 → no buf_read_en, no m_valid, done pulse; busy high exactly 1 cycle.
- start re-asserted mid-transfer with different base_addr → ignored; original sequence completes.
- rst asserted while FIFO holds 2 words → outputs 0 immediately; a subsequent length=1 transfer from address 7 produces only word 7 with m_last.
